spart_rx: RTL and testbench



---
 rtl/spart_pkg.sv | 19 +
 rtl/spart_rx_if.sv | 28 ++
 rtl/spart_rx_sync_2ff.sv | 22 ++
 rtl/spart_rx.sv | 138 +++++++++++++
 tb/tb_spart_rx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receive, transmit and bus-interface blocks.
package spart_pkg;

  // Receive state machine encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Bus address of the data register
  localparam logic [1:0] ADDR_DATA = 2'b00;

  // Default frame timing: 16 brg ticks per bit, 8 data bits
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/spart_rx_if.sv
// Processor-side bus of the SPART receiver: register access in, data/status out.
interface spart_rx_if
  import spart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic                 iocs;
  logic                 iorw;
  logic [1:0]           ioaddr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 ferr;
  logic                 ovr;

  // Processor side drives the access, reads back data and status
  modport master (
    output iocs, iorw, ioaddr,
    input  rx_data, rda, ferr, ovr
  );

  // Receiver side sees the access, drives data and status
  modport slave (
    input  iocs, iorw, ioaddr,
    output rx_data, rda, ferr, ovr
  );

endinterface

// File: rtl/spart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to let metastability on d settle before use
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer with 16x oversampling, mid-bit sampling,
// and a read-to-clear data register with rda/ferr/ovr status.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       brg_tick,
  spart_rx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [TW-1:0]        tick_cnt, tick_n;
  logic [3:0]           bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 rxd_s;
  logic                 rxd_prev;
  logic                 load;
  logic                 rd_strobe;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  assign rd_strobe = bus.iocs & bus.iorw & (bus.ioaddr == ADDR_DATA);

  // State, counters, shift register and the per-tick line history
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rxd_prev  <= 1'b1;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      if (brg_tick) begin
        rxd_prev <= rxd_s;
      end
    end
  end

  // Frame sequencing: start-edge detect, half-bit start check, data and stop sampling
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    load    = 1'b0;
    if (brg_tick) begin
      unique case (state)
        IDLE: begin
          if (!rxd_s && rxd_prev) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_HALF) begin
            tick_n = '0;
            if (!rxd_s) begin
              state_n = DATA;
              bit_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shift_n = {rxd_s, shift_reg[DATA_BITS-1:1]};
            tick_n  = '0;
            bit_n   = bit_cnt + 4'd1;
            if (bit_cnt == BIT_LAST) begin
              state_n = STOP;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == TICK_LAST) begin
            load    = 1'b1;
            tick_n  = '0;
            state_n = IDLE;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          tick_n  = '0;
        end
      endcase
    end
  end

  // Data register and status flags; a load on the same edge as a read wins
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_data <= '0;
      bus.rda     <= 1'b0;
      bus.ferr    <= 1'b0;
      bus.ovr     <= 1'b0;
    end else if (load) begin
      bus.rx_data <= shift_reg;
      bus.rda     <= 1'b1;
      bus.ferr    <= ~rxd_s;
      if (rd_strobe) begin
        bus.ovr <= 1'b0;
      end else if (bus.rda) begin
        bus.ovr <= 1'b1;
      end
    end else if (rd_strobe) begin
      bus.rda  <= 1'b0;
      bus.ferr <= 1'b0;
      bus.ovr  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Directed self-checking bench for spart_rx: brg_tick every 4 clk, 64 clk per bit.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic [1:0] tick_div = 2'd0;
  logic       brg_tick;
  int         passed = 0;
  int         total = 0;

  spart_rx_if #(.DATA_BITS(8)) bus ();

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .brg_tick (brg_tick),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign brg_tick = (tick_div == 2'd3);

  // Start each frame at a fixed phase so the stop sample lands 611 posedges after the start edge
  task automatic align_to_tick();
    @(negedge clk);
    while (tick_div != 2'd1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    align_to_tick();
    rxd = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (64) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (64) @(negedge clk);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
  endtask

  task automatic bus_access(input logic rw, input logic [1:0] addr);
    @(negedge clk);
    bus.iocs = 1'b1;
    bus.iorw = rw;
    bus.ioaddr = addr;
    @(negedge clk);
    bus.iocs = 1'b0;
    bus.iorw = 1'b0;
    bus.ioaddr = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    total++; if (bus.rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h want %h", bus.rx_data, 8'h00); else passed++;
    total++; if (bus.rda !== 1'b0) $display("[TB] FAIL reset_rda: got %b want 0", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL reset_ferr: got %b want 0", bus.ferr); else passed++;
    total++; if (bus.ovr !== 1'b0) $display("[TB] FAIL reset_ovr: got %b want 0", bus.ovr); else passed++;
  endtask

  task automatic test_good_frame();
    int  cnt = 0;
    bit  seen = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge rxd);
        while (!seen && cnt < 700) begin
          @(posedge clk);
          #1;
          cnt++;
          if (bus.rda === 1'b1) seen = 1;
        end
      end
    join
    total++; if (cnt < 604 || cnt > 612) $display("[TB] FAIL good_latency: got %0d clk want 604..612", cnt); else passed++;
    total++; if (bus.rx_data !== 8'h55) $display("[TB] FAIL good_rx_data: got %h want %h", bus.rx_data, 8'h55); else passed++;
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL good_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL good_ferr: got %b want 0", bus.ferr); else passed++;
    total++; if (bus.ovr !== 1'b0) $display("[TB] FAIL good_ovr: got %b want 0", bus.ovr); else passed++;
    bus_access(1'b1, 2'b00);
    total++; if (bus.rda !== 1'b0) $display("[TB] FAIL good_read_rda: got %b want 0", bus.rda); else passed++;
  endtask

  task automatic test_false_start();
    align_to_tick();
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (700) @(negedge clk);
    total++; if (bus.rda !== 1'b0) $display("[TB] FAIL false_start_rda: got %b want 0", bus.rda); else passed++;
    send_frame(8'hA5, 1'b1);
    total++; if (bus.rx_data !== 8'hA5) $display("[TB] FAIL after_false_rx_data: got %h want %h", bus.rx_data, 8'hA5); else passed++;
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL after_false_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL after_false_ferr: got %b want 0", bus.ferr); else passed++;
    bus_access(1'b1, 2'b00);
  endtask

  task automatic test_framing_error();
    send_frame(8'h3C, 1'b0);
    total++; if (bus.rx_data !== 8'h3C) $display("[TB] FAIL ferr_rx_data: got %h want %h", bus.rx_data, 8'h3C); else passed++;
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL ferr_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b1) $display("[TB] FAIL ferr_flag: got %b want 1", bus.ferr); else passed++;
    bus_access(1'b0, 2'b00);
    bus_access(1'b1, 2'b01);
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL ignored_access_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b1) $display("[TB] FAIL ignored_access_ferr: got %b want 1", bus.ferr); else passed++;
    bus_access(1'b1, 2'b00);
    total++; if (bus.rda !== 1'b0) $display("[TB] FAIL ferr_read_rda: got %b want 0", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL ferr_read_ferr: got %b want 0", bus.ferr); else passed++;
    total++; if (bus.rx_data !== 8'h3C) $display("[TB] FAIL ferr_read_rx_data: got %h want %h", bus.rx_data, 8'h3C); else passed++;
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    total++; if (bus.rx_data !== 8'h22) $display("[TB] FAIL ovr_rx_data: got %h want %h", bus.rx_data, 8'h22); else passed++;
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL ovr_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ovr !== 1'b1) $display("[TB] FAIL ovr_flag: got %b want 1", bus.ovr); else passed++;
    bus_access(1'b1, 2'b00);
    total++; if (bus.rda !== 1'b0) $display("[TB] FAIL ovr_read_rda: got %b want 0", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL ovr_read_ferr: got %b want 0", bus.ferr); else passed++;
    total++; if (bus.ovr !== 1'b0) $display("[TB] FAIL ovr_read_ovr: got %b want 0", bus.ovr); else passed++;
  endtask

  task automatic test_read_on_load();
    send_frame(8'h11, 1'b1);
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL rol_first_rda: got %b want 1", bus.rda); else passed++;
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(negedge rxd);
        repeat (610) @(posedge clk);
        @(negedge clk);
        bus.iocs = 1'b1;
        bus.iorw = 1'b1;
        bus.ioaddr = 2'b00;
        @(negedge clk);
        bus.iocs = 1'b0;
        bus.iorw = 1'b0;
      end
    join
    total++; if (bus.rx_data !== 8'h22) $display("[TB] FAIL rol_rx_data: got %h want %h", bus.rx_data, 8'h22); else passed++;
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL rol_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ovr !== 1'b0) $display("[TB] FAIL rol_ovr: got %b want 0", bus.ovr); else passed++;
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'h7E, 1'b1);
      begin
        @(negedge rxd);
        repeat (340) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (bus.rx_data !== 8'h00) $display("[TB] FAIL midrst_rx_data: got %h want %h", bus.rx_data, 8'h00); else passed++;
        total++; if (bus.rda !== 1'b0) $display("[TB] FAIL midrst_rda: got %b want 0", bus.rda); else passed++;
        total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL midrst_ferr: got %b want 0", bus.ferr); else passed++;
        total++; if (bus.ovr !== 1'b0) $display("[TB] FAIL midrst_ovr: got %b want 0", bus.ovr); else passed++;
      end
    join
    total++; if (bus.rda !== 1'b0) $display("[TB] FAIL midrst_no_load: got %b want 0", bus.rda); else passed++;
    // The low tail bit of 0x7E looks like a new start edge; let that frame finish and discard it
    repeat (800) @(negedge clk);
    bus_access(1'b1, 2'b00);
    send_frame(8'h81, 1'b1);
    total++; if (bus.rx_data !== 8'h81) $display("[TB] FAIL post_rst_rx_data: got %h want %h", bus.rx_data, 8'h81); else passed++;
    total++; if (bus.rda !== 1'b1) $display("[TB] FAIL post_rst_rda: got %b want 1", bus.rda); else passed++;
    total++; if (bus.ferr !== 1'b0) $display("[TB] FAIL post_rst_ferr: got %b want 0", bus.ferr); else passed++;
    total++; if (bus.ovr !== 1'b0) $display("[TB] FAIL post_rst_ovr: got %b want 0", bus.ovr); else passed++;
  endtask

  initial begin
    bus.iocs = 1'b0;
    bus.iorw = 1'b0;
    bus.ioaddr = 2'b00;
    test_reset();
    test_good_frame();
    test_false_start();
    test_framing_error();
    test_back_to_back();
    test_read_on_load();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
